stack_unit: RTL and testbench

//  Parametrised hardware LIFO stack: stack pointer plus word storage, next generation of the stack-pointer block.

---
 rtl/stack_unit.sv | 199 +++++++++++++++++++
 tb/tb_stack_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//   Parametrised descending LIFO stack (stack pointer plus word storage) used
//   beside the register file in the single-cycle datapath. The control unit's
//   stack op field selects 1- or 2-word push/pop, or a direct SP load.
//   Full/empty status and sticky overflow/underflow/load-error flags are kept.
//
//   Empty stack has SP=DEPTH, full stack has SP=0; the top word is mem[SP].
//
// Parameters
//   DATA_W  width of one stack word
//   DEPTH   number of words (>=2, any value)
//   SP_W    derived width of SP and count, $clog2(DEPTH+1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   op         000 hold, 001 pop1, 010 pop2, 011 push1, 100 push2,
//              101 load SP, 11x hold
//   wdata0     first push word
//   wdata1     second push word (push2 only)
//   sp_load    new SP value for load
//   err_clr    synchronous clear of ovf/unf/ld_err
//   sp_out     current stack pointer (index of top word)
//   count      occupancy, DEPTH - SP
//   top0       word at mem[SP], 0 when empty
//   top1       word at mem[SP+1], 0 when fewer than two words
//   full       count == DEPTH
//   empty      count == 0
//   ovf        sticky: push rejected for lack of space
//   unf        sticky: pop rejected for lack of data
//   ld_err     sticky: load rejected because sp_load > DEPTH
//   max_count  high-water occupancy
//
// Configuration
//   STACK_WATERMARK_EN  when defined, max_count is a register tracking the
//                       highest occupancy reached (cleared only by reset);
//                       otherwise max_count is tied to 0.
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [SP_W-1:0]   sp_load,
  input  logic              err_clr,
  output logic [SP_W-1:0]   sp_out,
  output logic [SP_W-1:0]   count,
  output logic [DATA_W-1:0] top0,
  output logic [DATA_W-1:0] top1,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf,
  output logic              ld_err,
  output logic [SP_W-1:0]   max_count
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] OP_POP1  = 3'b001;
  localparam logic [2:0] OP_POP2  = 3'b010;
  localparam logic [2:0] OP_PUSH1 = 3'b011;
  localparam logic [2:0] OP_PUSH2 = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;

  localparam logic [SP_W-1:0] DEPTH_S = SP_W'(DEPTH);
  localparam logic [SP_W:0]   DEPTH_E = (SP_W + 1)'(DEPTH);
  localparam logic [SP_W:0]   ONE_E   = (SP_W + 1)'(1);
  localparam logic [SP_W:0]   TWO_E   = (SP_W + 1)'(2);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]   sp;

  logic [SP_W:0]     sp_e;
  logic [SP_W:0]     sp_next_e;
  logic [SP_W-1:0]   sp_next;
  logic [SP_W-1:0]   count_next;
  logic              wr_one;
  logic              wr_two;
  logic              accepted;
  logic              ovf_set;
  logic              unf_set;
  logic              ld_set;
  logic [IDX_W-1:0]  idx_m1;
  logic [IDX_W-1:0]  idx_m2;

  // Decode the op and do the range checks one bit wider than SP so that
  // SP-2 on a near-full stack or SP+2 on a near-empty one cannot wrap.
  always_comb begin
    sp_e      = {1'b0, sp};
    sp_next_e = sp_e;
    wr_one    = 1'b0;
    wr_two    = 1'b0;
    accepted  = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    ld_set    = 1'b0;
    case (op)
      OP_POP1: begin
        if (sp_e + ONE_E <= DEPTH_E) begin
          sp_next_e = sp_e + ONE_E;
          accepted  = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_POP2: begin
        if (sp_e + TWO_E <= DEPTH_E) begin
          sp_next_e = sp_e + TWO_E;
          accepted  = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_PUSH1: begin
        if (sp_e >= ONE_E) begin
          sp_next_e = sp_e - ONE_E;
          wr_one    = 1'b1;
          accepted  = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_PUSH2: begin
        // All-or-nothing: a push2 with only one free slot writes nothing.
        if (sp_e >= TWO_E) begin
          sp_next_e = sp_e - TWO_E;
          wr_one    = 1'b1;
          wr_two    = 1'b1;
          accepted  = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_LOAD: begin
        if ({1'b0, sp_load} <= DEPTH_E) begin
          sp_next_e = {1'b0, sp_load};
          accepted  = 1'b1;
        end else begin
          ld_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sp_next    = sp_next_e[SP_W-1:0];
  assign count_next = DEPTH_S - sp_next;
  assign idx_m1     = IDX_W'(sp - SP_W'(1));
  assign idx_m2     = IDX_W'(sp - SP_W'(2));

  // Stack pointer, sticky flags and storage. Storage is deliberately left
  // out of the reset branch so it is plain RAM; an op presented while reset
  // is high therefore never writes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp     <= DEPTH_S;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      sp     <= sp_next;
      ovf    <= (ovf    & ~err_clr) | ovf_set;
      unf    <= (unf    & ~err_clr) | unf_set;
      ld_err <= (ld_err & ~err_clr) | ld_set;
      if (wr_one) mem[idx_m1] <= wdata0;
      if (wr_two) mem[idx_m2] <= wdata1;
    end
  end

`ifdef STACK_WATERMARK_EN
  // High-water mark of occupancy; a load is treated like any other change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_count <= '0;
    end else if (accepted && (count_next > max_count)) begin
      max_count <= count_next;
    end
  end
`else
  assign max_count = '0;
`endif

  assign sp_out = sp;
  assign count  = DEPTH_S - sp;
  assign full   = (sp == '0);
  assign empty  = (sp == DEPTH_S);

  // Guarded reads keep the index inside the storage even when SP=DEPTH.
  assign top0 = (count >= SP_W'(1)) ? mem[IDX_W'(sp)] : '0;
  assign top1 = (count >= SP_W'(2)) ? mem[IDX_W'(sp + SP_W'(1))] : '0;

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
//   Directed self-checking bench for stack_unit with DATA_W=8, DEPTH=4.
//   Expected values are hand-computed; the watermark expectations follow
//   STACK_WATERMARK_EN so the bench works for both builds.
// -----------------------------------------------------------------------------
module tb_stack_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SP_W   = 3;

  logic              clk;
  logic              reset;
  logic [2:0]        op;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [SP_W-1:0]   sp_load;
  logic              err_clr;
  logic [SP_W-1:0]   sp_out;
  logic [SP_W-1:0]   count;
  logic [DATA_W-1:0] top0;
  logic [DATA_W-1:0] top1;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;
  logic              ld_err;
  logic [SP_W-1:0]   max_count;

  int checks;
  int passed;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .sp_load   (sp_load),
    .err_clr   (err_clr),
    .sp_out    (sp_out),
    .count     (count),
    .top0      (top0),
    .top1      (top1),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .unf       (unf),
    .ld_err    (ld_err),
    .max_count (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op on the falling edge, let the rising edge take it, then
  // return to hold so later idle cycles change nothing.
  task automatic do_op(input logic [2:0] o, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [2:0] ld,
                       input logic clr);
    @(negedge clk);
    op = o; wdata0 = d0; wdata1 = d1; sp_load = ld; err_clr = clr;
    @(posedge clk);
    #1;
    op = 3'b000; err_clr = 1'b0;
  endtask

  function automatic logic [2:0] wm(input logic [2:0] v);
`ifdef STACK_WATERMARK_EN
    return v;
`else
    return 3'd0 & v;
`endif
  endfunction

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (sp_out !== 3'd4) $display("FAIL reset_sp got %0d want 4", sp_out); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    checks++; if ({empty, full} !== 2'b10) $display("FAIL reset_empty_full got %b want 10", {empty, full}); else passed++;
    checks++; if ({ovf, unf, ld_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ovf, unf, ld_err}); else passed++;
    checks++; if ({top0, top1} !== 16'h0000) $display("FAIL reset_tops got %h want 0000", {top0, top1}); else passed++;
    checks++; if (max_count !== 3'd0) $display("FAIL reset_max got %0d want 0", max_count); else passed++;
  endtask

  task automatic test_push_pop();
    $display("[TB] test_push_pop");
    do_op(3'b011, 8'hA1, 8'h00, 3'd0, 1'b0);
    checks++; if ({count, top0, top1} !== {3'd1, 8'hA1, 8'h00}) $display("FAIL push1 got cnt=%0d t0=%h t1=%h want 1 a1 00", count, top0, top1); else passed++;
    do_op(3'b100, 8'hB1, 8'hB2, 3'd0, 1'b0);
    checks++; if ({count, top0, top1} !== {3'd3, 8'hB2, 8'hB1}) $display("FAIL push2 got cnt=%0d t0=%h t1=%h want 3 b2 b1", count, top0, top1); else passed++;
    checks++; if (sp_out !== 3'd1) $display("FAIL push2_sp got %0d want 1", sp_out); else passed++;
    do_op(3'b010, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if ({count, top0, top1} !== {3'd1, 8'hA1, 8'h00}) $display("FAIL pop2 got cnt=%0d t0=%h t1=%h want 1 a1 00", count, top0, top1); else passed++;
    checks++; if (max_count !== wm(3'd3)) $display("FAIL wm_after_push2 got %0d want %0d", max_count, wm(3'd3)); else passed++;
    do_op(3'b110, 8'hEE, 8'hEE, 3'd0, 1'b0);
    checks++; if ({sp_out, ovf, unf, ld_err} !== {3'd3, 3'b000}) $display("FAIL op11x_hold got sp=%0d f=%b want 3 000", sp_out, {ovf, unf, ld_err}); else passed++;
  endtask

  task automatic test_overflow();
    $display("[TB] test_overflow");
    do_op(3'b100, 8'hC1, 8'hC2, 3'd0, 1'b0);
    checks++; if ({count, top0, top1} !== {3'd3, 8'hC2, 8'hC1}) $display("FAIL fill_push2 got cnt=%0d t0=%h t1=%h want 3 c2 c1", count, top0, top1); else passed++;
    do_op(3'b100, 8'hE1, 8'hE2, 3'd0, 1'b0);
    checks++; if ({ovf, count, top0, top1} !== {1'b1, 3'd3, 8'hC2, 8'hC1}) $display("FAIL push2_one_free got ovf=%b cnt=%0d t0=%h t1=%h want 1 3 c2 c1", ovf, count, top0, top1); else passed++;
    do_op(3'b000, 8'h00, 8'h00, 3'd0, 1'b1);
    checks++; if (ovf !== 1'b0) $display("FAIL errclr_ovf got %b want 0", ovf); else passed++;
    do_op(3'b011, 8'hD1, 8'h00, 3'd0, 1'b0);
    checks++; if ({full, count, top0, top1} !== {1'b1, 3'd4, 8'hD1, 8'hC2}) $display("FAIL fill_push1 got full=%b cnt=%0d t0=%h t1=%h want 1 4 d1 c2", full, count, top0, top1); else passed++;
    do_op(3'b011, 8'hFF, 8'h00, 3'd0, 1'b0);
    checks++; if ({ovf, full, count, top0} !== {2'b11, 3'd4, 8'hD1}) $display("FAIL push_full got ovf=%b full=%b cnt=%0d t0=%h want 1 1 4 d1", ovf, full, count, top0); else passed++;
    do_op(3'b011, 8'hFF, 8'h00, 3'd0, 1'b1);
    checks++; if (ovf !== 1'b1) $display("FAIL clr_with_new_err got %b want 1", ovf); else passed++;
    do_op(3'b000, 8'h00, 8'h00, 3'd0, 1'b1);
    checks++; if (ovf !== 1'b0) $display("FAIL errclr_ovf2 got %b want 0", ovf); else passed++;
    checks++; if (max_count !== wm(3'd4)) $display("FAIL wm_full got %0d want %0d", max_count, wm(3'd4)); else passed++;
  endtask

  task automatic test_underflow();
    $display("[TB] test_underflow");
    do_op(3'b010, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if ({count, top0, top1} !== {3'd2, 8'hC1, 8'hA1}) $display("FAIL pop2_from_full got cnt=%0d t0=%h t1=%h want 2 c1 a1", count, top0, top1); else passed++;
    do_op(3'b001, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if ({count, top0, top1} !== {3'd1, 8'hA1, 8'h00}) $display("FAIL pop1 got cnt=%0d t0=%h t1=%h want 1 a1 00", count, top0, top1); else passed++;
    do_op(3'b010, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if ({unf, count, top0} !== {1'b1, 3'd1, 8'hA1}) $display("FAIL pop2_short got unf=%b cnt=%0d t0=%h want 1 1 a1", unf, count, top0); else passed++;
    do_op(3'b001, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if ({empty, count, sp_out, top0} !== {1'b1, 3'd0, 3'd4, 8'h00}) $display("FAIL pop_to_empty got e=%b cnt=%0d sp=%0d t0=%h want 1 0 4 00", empty, count, sp_out, top0); else passed++;
    do_op(3'b001, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if ({unf, sp_out} !== {1'b1, 3'd4}) $display("FAIL pop_empty got unf=%b sp=%0d want 1 4", unf, sp_out); else passed++;
  endtask

  task automatic test_load();
    $display("[TB] test_load");
    do_op(3'b000, 8'h00, 8'h00, 3'd0, 1'b1);
    checks++; if (unf !== 1'b0) $display("FAIL errclr_unf got %b want 0", unf); else passed++;
    do_op(3'b101, 8'h00, 8'h00, 3'd5, 1'b0);
    checks++; if ({ld_err, sp_out} !== {1'b1, 3'd4}) $display("FAIL load_bad got err=%b sp=%0d want 1 4", ld_err, sp_out); else passed++;
    do_op(3'b101, 8'h00, 8'h00, 3'd2, 1'b0);
    checks++; if ({count, sp_out, ld_err} !== {3'd2, 3'd2, 1'b1}) $display("FAIL load_2 got cnt=%0d sp=%0d err=%b want 2 2 1", count, sp_out, ld_err); else passed++;
    checks++; if ({top0, top1} !== {8'hC1, 8'hA1}) $display("FAIL load_keeps_mem got %h want c1a1", {top0, top1}); else passed++;
    checks++; if (max_count !== wm(3'd4)) $display("FAIL wm_after_load got %0d want %0d", max_count, wm(3'd4)); else passed++;
    do_op(3'b101, 8'h00, 8'h00, 3'd3, 1'b1);
    checks++; if ({ld_err, count, top0} !== {1'b0, 3'd1, 8'hA1}) $display("FAIL load_with_clr got err=%b cnt=%0d t0=%h want 0 1 a1", ld_err, count, top0); else passed++;
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    do_op(3'b010, 8'h00, 8'h00, 3'd0, 1'b0);
    checks++; if (unf !== 1'b1) $display("FAIL pre_reset_unf got %b want 1", unf); else passed++;
    @(negedge clk);
    op = 3'b100; wdata0 = 8'hF1; wdata1 = 8'hF2;
    #2 reset = 1'b1;
    #1;
    checks++; if ({sp_out, ovf, unf, ld_err, max_count} !== {3'd4, 3'b000, 3'd0}) $display("FAIL async_reset got sp=%0d f=%b max=%0d want 4 000 0", sp_out, {ovf, unf, ld_err}, max_count); else passed++;
    @(posedge clk);
    #1;
    checks++; if (sp_out !== 3'd4) $display("FAIL reset_ignores_op got %0d want 4", sp_out); else passed++;
    @(negedge clk);
    reset = 1'b0; op = 3'b000;
    #1;
    checks++; if ({count, top0} !== {3'd0, 8'h00}) $display("FAIL after_release got cnt=%0d t0=%h want 0 00", count, top0); else passed++;
    do_op(3'b101, 8'h00, 8'h00, 3'd2, 1'b0);
    checks++; if ({top0, top1} !== {8'hC1, 8'hA1}) $display("FAIL no_write_in_reset got %h want c1a1", {top0, top1}); else passed++;
    checks++; if (max_count !== wm(3'd2)) $display("FAIL wm_after_reset got %0d want %0d", max_count, wm(3'd2)); else passed++;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset   = 1'b1;
    op      = 3'b000;
    wdata0  = '0;
    wdata1  = '0;
    sp_load = '0;
    err_clr = 1'b0;
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
